// File: rtl/exec_mem_responder.sv
// Word-addressed memory responder for the execution unit's read/write port.
// Fixed-latency pipelined reads with write-first forwarding and an optional post-reset clear.
module exec_mem_responder #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 12,
    parameter int unsigned RD_LATENCY     = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic                  rd_valid,
    output logic                  mem_ready,
    output logic                  req_err,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    typedef enum logic {StClear, StReady} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;

    logic [DATA_WIDTH-1:0]   mem_q [Depth];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic                    rd_acc, wr_acc, err_set;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic [RD_LATENCY-1:0]   pipe_vld_q, pipe_vld_d;
    logic [RD_LATENCY:0]     vld_in;
    logic [DATA_WIDTH-1:0]   pipe_data_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_data_d [RD_LATENCY];
    logic [DATA_WIDTH-1:0]   data_in     [RD_LATENCY+1];

    logic                    req_err_q, req_err_d;
    logic [15:0]             rd_count_q, rd_count_d;
    logic [15:0]             wr_count_q, wr_count_d;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CLEAR_ON_RESET ? StClear : StReady;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StClear: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = StReady;
                end
            end
            StReady: state_d = StReady;
            default: state_d = StReady;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_ready = (state_q == StReady);
        rd_acc    = mem_ready & exec_rd_req;
        wr_acc    = mem_ready & exec_wr_req;
        err_set   = ~mem_ready & (exec_rd_req | exec_wr_req);
    end

    // Single write port shared by the clear sequencer and the execution unit.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_addr_q;
        mem_wdata = '0;
        if (!mem_ready) begin
            mem_we = 1'b1;
        end else if (wr_acc) begin
            mem_we    = 1'b1;
            mem_waddr = exec_wr_addr;
            mem_wdata = exec_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Write-first: a same-cycle write to the read address wins over stale array data.
    always_comb begin
        if (exec_wr_req && (exec_wr_addr == exec_rd_addr)) begin
            rd_word = exec_wr_data;
        end else begin
            rd_word = mem_q[exec_rd_addr];
        end
    end

    // Each stage loads only when a valid word enters it, so the last stage holds its value.
    always_comb begin
        vld_in     = {pipe_vld_q, rd_acc};
        pipe_vld_d = vld_in[RD_LATENCY-1:0];
        data_in[0] = rd_word;
        for (int i = 1; i <= RD_LATENCY; i++) begin
            data_in[i] = pipe_data_q[i-1];
        end
        for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_data_d[i] = vld_in[i] ? data_in[i] : pipe_data_q[i];
        end
    end

    always_comb begin
        req_err_d  = req_err_q | err_set;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (rd_acc && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
        end
        if (wr_acc && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
            req_err_q  <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_data_q[i] <= pipe_data_d[i];
            end
            req_err_q  <= req_err_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign exec_rd_data = pipe_data_q[RD_LATENCY-1];
    assign rd_valid     = pipe_vld_q[RD_LATENCY-1];
    assign req_err      = req_err_q;
    assign rd_count     = rd_count_q;
    assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_exec_mem_responder.sv
// Scoreboard bench: a default instance (latency 1, clear on reset) and a latency-3 instance
// without clear, each checked against an array model of the memory.
module tb_exec_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, rst3 = 1'b1;
    logic        rd_req1 = 0, wr_req1 = 0, rd_req3 = 0, wr_req3 = 0;
    logic [11:0] rd_addr1 = 0, wr_addr1 = 0, wr_data1 = 0;
    logic [11:0] rd_addr3 = 0, wr_addr3 = 0, wr_data3 = 0;
    logic [11:0] rd_data1, rd_data3;
    logic        rd_valid1, mem_ready1, req_err1, rd_valid3, mem_ready3, req_err3;
    logic [15:0] rd_count1, wr_count1, rd_count3, wr_count3;

    exec_mem_responder dut1 (
        .clk(clk), .reset(reset),
        .exec_rd_req(rd_req1), .exec_rd_addr(rd_addr1), .exec_rd_data(rd_data1),
        .exec_wr_req(wr_req1), .exec_wr_addr(wr_addr1), .exec_wr_data(wr_data1),
        .rd_valid(rd_valid1), .mem_ready(mem_ready1), .req_err(req_err1),
        .rd_count(rd_count1), .wr_count(wr_count1)
    );

    exec_mem_responder #(.RD_LATENCY(3), .CLEAR_ON_RESET(1'b0)) dut3 (
        .clk(clk), .reset(rst3),
        .exec_rd_req(rd_req3), .exec_rd_addr(rd_addr3), .exec_rd_data(rd_data3),
        .exec_wr_req(wr_req3), .exec_wr_addr(wr_addr3), .exec_wr_data(wr_data3),
        .rd_valid(rd_valid3), .mem_ready(mem_ready3), .req_err(req_err3),
        .rd_count(rd_count3), .wr_count(wr_count3)
    );

    typedef struct {
        logic [11:0] data;
        int          due;
    } exp_t;

    int unsigned n_vec = 0, n_bad = 0;
    int          cyc = 0;
    exp_t        q1[$], q3[$];
    logic [11:0] mem1 [4096];
    logic [11:0] mem3 [4096];
    bit          ready1_m = 0;
    int unsigned rdc1_m = 0, wrc1_m = 0, rdc3_m = 0, wrc3_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned inc16(input int unsigned v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Monitors: a response is due exactly in the cycle recorded at issue time.
    always @(negedge clk) begin
        exp_t e;
        bit   due_now;
        if (!reset) begin
            due_now = (q1.size() != 0) && (q1[0].due == cyc);
            chk("rd1_valid", {31'b0, rd_valid1}, {31'b0, due_now});
            if (rd_valid1 && q1.size() != 0) begin
                e = q1.pop_front();
                chk("rd1_data", {20'b0, rd_data1}, {20'b0, e.data});
            end else if (due_now) begin
                void'(q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   due_now;
        if (!rst3) begin
            due_now = (q3.size() != 0) && (q3[0].due == cyc);
            chk("rd3_valid", {31'b0, rd_valid3}, {31'b0, due_now});
            if (rd_valid3 && q3.size() != 0) begin
                e = q3.pop_front();
                chk("rd3_data", {20'b0, rd_data3}, {20'b0, e.data});
            end else if (due_now) begin
                void'(q3.pop_front());
            end
        end
    end

    task automatic step1(input bit rd, input logic [11:0] ra, input bit wr,
                         input logic [11:0] wa, input logic [11:0] wd);
        exp_t e;
        @(posedge clk);
        #1;
        rd_req1 = rd; rd_addr1 = ra; wr_req1 = wr; wr_addr1 = wa; wr_data1 = wd;
        rd_req3 = 0; wr_req3 = 0;
        if (ready1_m) begin
            if (rd) begin
                e.data = (wr && wa == ra) ? wd : mem1[ra];
                e.due  = cyc + 1;
                q1.push_back(e);
                rdc1_m = inc16(rdc1_m);
            end
            if (wr) begin
                mem1[wa] = wd;
                wrc1_m   = inc16(wrc1_m);
            end
        end
    endtask

    task automatic step3(input bit rd, input logic [11:0] ra, input bit wr,
                         input logic [11:0] wa, input logic [11:0] wd);
        exp_t e;
        @(posedge clk);
        #1;
        rd_req3 = rd; rd_addr3 = ra; wr_req3 = wr; wr_addr3 = wa; wr_data3 = wd;
        rd_req1 = 0; wr_req1 = 0;
        if (rd) begin
            e.data = (wr && wa == ra) ? wd : mem3[ra];
            e.due  = cyc + 3;
            q3.push_back(e);
            rdc3_m = inc16(rdc3_m);
        end
        if (wr) begin
            mem3[wa] = wd;
            wrc3_m   = inc16(wrc3_m);
        end
    endtask

    // Counts the not-ready cycles after release; optionally fires requests mid-clear.
    task automatic wait_ready1(input bit inject);
        int n = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (mem_ready1) break;
            n++;
            if (inject && n == 10) begin
                rd_req1 = 1; rd_addr1 = 12'($urandom);
                wr_req1 = 1; wr_addr1 = rd_addr1; wr_data1 = 12'($urandom);
            end
            if (inject && n == 12) begin
                rd_req1 = 0; wr_req1 = 0;
            end
        end
        chk("clear_cycles", n, 4096);
        for (int a = 0; a < 4096; a++) mem1[a] = '0;
        ready1_m = 1;
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, "_rd_data"}, {20'b0, rd_data1}, 0);
        chk({tag, "_rd_valid"}, {31'b0, rd_valid1}, 0);
        chk({tag, "_mem_ready"}, {31'b0, mem_ready1}, 0);
        chk({tag, "_req_err"}, {31'b0, req_err1}, 0);
        chk({tag, "_rd_count"}, {16'b0, rd_count1}, 0);
        chk({tag, "_wr_count"}, {16'b0, wr_count1}, 0);
    endtask

    task automatic chk_counts(input string tag);
        @(negedge clk);
        chk({tag, "_rd_count1"}, {16'b0, rd_count1}, rdc1_m);
        chk({tag, "_wr_count1"}, {16'b0, wr_count1}, wrc1_m);
        chk({tag, "_rd_count3"}, {16'b0, rd_count3}, rdc3_m);
        chk({tag, "_wr_count3"}, {16'b0, wr_count3}, wrc3_m);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a, b;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset1("reset");
        @(posedge clk);
        #1;
        reset = 0;
        rst3  = 0;

        // Requests during the clear are dropped but flagged.
        wait_ready1(1'b1);
        chk("req_err_sticky", {31'b0, req_err1}, 1);
        chk("ready3", {31'b0, mem_ready3}, 1);
        chk_counts("after_clear");

        // Directed: write then read, cleared top word, same-cycle forwarding.
        step1(0, 0, 1, 12'o0200, 12'o1234);
        step1(1, 12'o0200, 0, 0, 0);
        step1(1, 12'o7777, 0, 0, 0);
        step1(1, 12'o0020, 1, 12'o0020, 12'o7777);
        step1(0, 0, 0, 0, 0);
        step1(0, 0, 0, 0, 0);
        chk_counts("directed");

        for (int i = 0; i < 1000; i++) begin
            a = 12'($urandom_range(0, 63));
            b = ($urandom_range(0, 3) == 0) ? a : 12'($urandom_range(0, 63));
            step1(1'($urandom), a, 1'($urandom), b, 12'($urandom));
        end
        step1(0, 0, 0, 0, 0);
        step1(0, 0, 0, 0, 0);
        chk_counts("random1");

        // Latency-3 instance: preload, ordered reads, late write must not disturb data.
        for (int i = 0; i < 32; i++) step3(0, 0, 1, 12'(i), 12'($urandom));
        step3(0, 0, 1, 12'o0001, 12'o0011);
        step3(0, 0, 1, 12'o0002, 12'o0022);
        step3(0, 0, 1, 12'o0003, 12'o0033);
        step3(1, 12'o0001, 0, 0, 0);
        step3(1, 12'o0002, 0, 0, 0);
        step3(1, 12'o0003, 1, 12'o0002, 12'o7777);
        step3(1, 12'o0002, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            a = 12'($urandom_range(0, 31));
            b = ($urandom_range(0, 3) == 0) ? a : 12'($urandom_range(0, 31));
            step3(1'($urandom), a, 1'($urandom), b, 12'($urandom));
        end
        repeat (4) step3(0, 0, 0, 0, 0);
        chk_counts("random3");
        chk("req_err3", {31'b0, req_err3}, 0);

        // Reset while a read response is on the outputs.
        step1(1, 12'o0200, 0, 0, 0);
        step1(0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        reset = 1;
        #1;
        chk_reset1("reset_mid_read");
        q1.delete();
        ready1_m = 0; rdc1_m = 0; wrc1_m = 0;
        @(posedge clk);
        #1;
        reset = 0;

        // Reset again once the clear has reached address 2000 (octal).
        repeat (1025) @(negedge clk);
        #2;
        reset = 1;
        #1;
        chk_reset1("reset_mid_clear");
        @(posedge clk);
        #1;
        reset = 0;
        wait_ready1(1'b0);
        chk("req_err_clean", {31'b0, req_err1}, 0);

        // Saturation of the read counter, with some writes mixed in.
        for (int i = 0; i < 65540; i++) begin
            a = 12'($urandom_range(0, 255));
            step1(1, a, ($urandom_range(0, 7) == 0), 12'($urandom_range(0, 255)),
                  12'($urandom));
        end
        step1(0, 0, 0, 0, 0);
        step1(0, 0, 0, 0, 0);
        chk_counts("saturate");
        chk("rd_count_sat", {16'b0, rd_count1}, 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_mem_responder.md
# exec_mem_responder

Synthesizable word-addressed memory that answers the execution unit's read/write port (exec_rd_*/exec_wr_*), acting as the responder end of that interface in place of the behavioural memory model. It stores 2^ADDR_WIDTH words of DATA_WIDTH bits and returns read data after a fixed pipelined latency with write-first forwarding. An optional post-reset clear sequencer zeroes the array before accepting requests. Access counters and a sticky error flag support the interface checker.

## Interface
- ADDR_WIDTH, 12, word address width (PDP-8 4K field)
- DATA_WIDTH, 12, word width
- RD_LATENCY, 1, read latency in cycles, legal range 1..4
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip the clear
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- exec_rd_req  in  1  read request, one read per cycle high
- exec_rd_addr  in  ADDR_WIDTH  read address
- exec_rd_data  out  DATA_WIDTH  read data
- exec_wr_req  in  1  write request, one write per cycle high
- exec_wr_addr  in  ADDR_WIDTH  write address
- exec_wr_data  in  DATA_WIDTH  write data
- rd_valid  out  1  exec_rd_data carries the response to an accepted read
- mem_ready  out  1  clear done; requests are accepted
- req_err  out  1  sticky: a request arrived while mem_ready=0
- rd_count  out  16  accepted reads, saturating
- wr_count  out  16  accepted writes, saturating

## Operation
- Reset values: exec_rd_data=0, rd_valid=0, mem_ready=0, req_err=0, rd_count=0, wr_count=0. All read-pipeline valid bits are cleared. Array contents are not reset.
- The state machine has two states, CLEAR and READY.
  - Reset enters CLEAR when CLEAR_ON_RESET=1, else READY.
  - CLEAR: clr_addr counts 0 to 2^ADDR_WIDTH-1 and writes 0 to one address per cycle. After the last address is written, the block moves to READY.
  - READY is terminal until the next reset.
- mem_ready=1 exactly when the state is READY.
- In CLEAR, exec_rd_req and exec_wr_req are dropped: no array access, no count, no rd_valid. Either request sets req_err, which holds until reset.
- In READY, a write with exec_wr_req=1 updates the array at the clock edge.
- In READY, a read with exec_rd_req=1 samples data in the same cycle:
  - If exec_wr_req=1 and exec_wr_addr equals exec_rd_addr, the sampled data is exec_wr_data (write-first).
  - Otherwise it is the array content at exec_rd_addr.
- The sampled word travels through RD_LATENCY register stages, each with its own valid bit. It is not altered by writes that occur after sampling.
- exec_rd_data updates only when a valid word exits the pipeline; otherwise it holds its last value. rd_valid is the valid bit of the last stage.
- Simultaneous read and write to different addresses are both serviced.
- rd_count/wr_count increment by 1 per accepted request and stick at 16'hFFFF.
- Addresses always lie within the array, so no out-of-range condition exists.

## Timing
- Read accepted in cycle N gives rd_valid=1 and data in cycle N+RD_LATENCY. With RD_LATENCY=1 this is the next cycle.
- The read path is fully pipelined: reads in consecutive cycles produce consecutive rd_valid cycles in request order.
- A write in cycle N is visible to a read in cycle N through forwarding, and through the array from cycle N+1 onward.
- With CLEAR_ON_RESET=1, mem_ready rises in cycle 2^ADDR_WIDTH after reset deasserts: 4096 cycles at default width. The first accepted request is in that cycle.
- With CLEAR_ON_RESET=0, mem_ready=1 in the first cycle after reset deasserts.
- Reset asserted mid-clear or mid-read: outputs go to reset values asynchronously and in-flight reads are discarded. After release, the clear restarts at address 0.
- rd_count/wr_count update one cycle after the accepting cycle.

## Test plan
- Reset, CLEAR_ON_RESET=1 -> mem_ready=0 for 4096 cycles, then 1. Read of 12'o7777 returns 12'o0000 with rd_valid one cycle later.
- Write 12'o0200 <- 12'o1234, then read 12'o0200 the next cycle -> exec_rd_data=12'o1234, rd_valid=1 one cycle after the read, rd_count=1, wr_count=1.
- Same cycle: write 12'o0020 <- 12'o7777 and read 12'o0020, where old content is 12'o0000 -> read returns 12'o7777.
- RD_LATENCY=3: reads of 12'o0001, 12'o0002, 12'o0003 (preloaded 12'o0011, 12'o0022, 12'o0033) in cycles N..N+2 -> rd_valid in cycles N+3..N+5 with data in order. A write to 12'o0002 in cycle N+2 does not change the returned 12'o0022.
- Read and write during CLEAR -> dropped, req_err=1 and stays 1, no rd_valid, counts remain 0.
- Reset asserted when clr_addr=12'o2000 -> outputs reset immediately. mem_ready rises 4096 cycles after release. Drive 65540 reads -> rd_count saturates at 16'hFFFF.
